// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath constants and types
// Purpose: word width, default return-stack depth and the word type
//          shared by the return stack and its register file.
// Ports:   none (package).
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int STACK_DEPTH = 8;

  typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - return-stack storage array
// Purpose: DEPTH x DATA_W storage with one synchronous write port and one
//          asynchronous read port. Contents are not reset.
// Ports:
//   clk              rising-edge clock for the write port
//   i_we             write enable
//   i_waddr [AW-1:0] write address
//   i_wdata [DW-1:0] write data
//   i_raddr [AW-1:0] read address
//   o_rdata [DW-1:0] read data, combinational from i_raddr
module stack_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset on the array: an empty stack never exposes its contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : stack_regfile

// File: rtl/return_stack.sv
// rtl/return_stack.sv - hardware LIFO for return addresses and data words
// Purpose: CALL pushes PC_current+1, PSH pushes PUSH_input, STACK_POP pops.
//          POP_output always shows the current top so the PC mux can load
//          it in the same cycle STACK_POP is asserted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   PC_current [DW-1:0]   PC of the current instruction
//   CALL / PSH            push PC_current+1 / push PUSH_input (CALL wins)
//   PUSH_input [DW-1:0]   data word for PSH
//   STACK_POP             pop the top entry
//   clr_err               clear sticky error flags
//   POP_output [DW-1:0]   top entry, 0 when empty
//   stack_empty/full      occupancy status
//   depth [PTR_W:0]       occupancy 0..DEPTH
//   overflow/underflow    sticky error flags
module return_stack
  import cpu_pkg::*;
#(
  parameter  int DATA_W = cpu_pkg::DATA_W,
  parameter  int DEPTH  = STACK_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] PC_current,
  input  logic              CALL,
  input  logic              PSH,
  input  logic [DATA_W-1:0] PUSH_input,
  input  logic              STACK_POP,
  input  logic              clr_err,
  output logic [DATA_W-1:0] POP_output,
  output logic              stack_empty,
  output logic              stack_full,
  output logic [PTR_W:0]    depth,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]    r_sp;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic [DATA_W-1:0] w_push_word;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_rdata;
  logic [PTR_W:0]    w_sp_next;
  logic              w_ov_set;
  logic              w_un_set;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SP_FULL);
  assign w_push  = CALL | PSH;

  // CALL has priority; the return address wraps modulo 2^DATA_W.
  assign w_push_word = CALL ? (PC_current + DATA_W'(1)) : PUSH_input;

  // Index of the top entry. At sp==DEPTH the low bits are 0 and the
  // subtraction wraps to DEPTH-1, which is the correct top slot.
  assign w_top_idx = r_sp[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_sp[PTR_W-1:0];
    w_sp_next = r_sp;
    w_ov_set  = 1'b0;
    w_un_set  = 1'b0;
    if (STACK_POP) begin
      if (w_empty) begin
        // Pop on empty; a simultaneous push is dropped.
        w_un_set = 1'b1;
      end else if (w_push) begin
        // Replace: overwrite the top in place, sp unchanged, legal when full.
        w_we    = 1'b1;
        w_waddr = w_top_idx;
      end else begin
        w_sp_next = r_sp - (PTR_W+1)'(1);
      end
    end else if (w_push) begin
      if (w_full) begin
        w_ov_set = 1'b1;
      end else begin
        w_we      = 1'b1;
        w_sp_next = r_sp + (PTR_W+1)'(1);
      end
    end
  end

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_push_word),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp        <= w_sp_next;
      // A new error in the same cycle as clr_err keeps the flag set.
      r_overflow  <= w_ov_set | (r_overflow  & ~clr_err);
      r_underflow <= w_un_set | (r_underflow & ~clr_err);
    end
  end

  assign POP_output  = w_empty ? '0 : w_rdata;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign depth       = r_sp;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule : return_stack

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - self-checking bench for return_stack
module tb_return_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] PC_current = '0;
  logic        CALL = 1'b0;
  logic        PSH = 1'b0;
  logic [15:0] PUSH_input = '0;
  logic        STACK_POP = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] POP_output;
  logic        stack_empty;
  logic        stack_full;
  logic [3:0]  depth;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] mstk[$];
  logic [15:0] exp_q[$];
  logic        m_ov = 1'b0;
  logic        m_un = 1'b0;

  always #5 clk = ~clk;

  return_stack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_current (PC_current),
    .CALL       (CALL),
    .PSH        (PSH),
    .PUSH_input (PUSH_input),
    .STACK_POP  (STACK_POP),
    .clr_err    (clr_err),
    .POP_output (POP_output),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_top();
    return (mstk.size() == 0) ? 16'h0000 : mstk[$];
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".depth"},    32'(depth),       32'(mstk.size()));
    check({tag, ".empty"},    32'(stack_empty), 32'(mstk.size() == 0));
    check({tag, ".full"},     32'(stack_full),  32'(mstk.size() == 8));
    check({tag, ".ovf"},      32'(overflow),    32'(m_ov));
    check({tag, ".unf"},      32'(underflow),   32'(m_un));
    check({tag, ".top"},      32'(POP_output),  32'(m_top()));
  endtask

  // One clock cycle of stimulus; inputs driven just after the falling edge.
  task automatic step(input logic c, input logic p, input logic [15:0] pc,
                      input logic [15:0] pin, input logic pp, input logic cl);
    logic [15:0] word;
    logic [15:0] e;
    logic        ov_set;
    logic        un_set;
    CALL = c; PSH = p; PC_current = pc; PUSH_input = pin;
    STACK_POP = pp; clr_err = cl;
    if (pp) exp_q.push_back(m_top());
    #1;
    if (pp) begin
      e = exp_q.pop_front();
      check("pop_cycle_out", 32'(POP_output), 32'(e));
    end
    word   = c ? pc + 16'd1 : pin;
    ov_set = 1'b0;
    un_set = 1'b0;
    if (pp) begin
      if (mstk.size() == 0) un_set = 1'b1;
      else if (c | p) mstk[mstk.size()-1] = word;
      else void'(mstk.pop_back());
    end else if (c | p) begin
      if (mstk.size() == 8) ov_set = 1'b1;
      else mstk.push_back(word);
    end
    m_ov = ov_set | (m_ov & ~cl);
    m_un = un_set | (m_un & ~cl);
    @(posedge clk);
    @(negedge clk);
    CALL = 0; PSH = 0; STACK_POP = 0; clr_err = 0;
    #1;
    check_state("step");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("reset");
    repeat (3) step(0, 0, 0, 0, 0, 0);
    check("idle_top", 32'(POP_output), 32'h0);

    step(1, 0, 16'h0010, 0, 0, 0);
    step(0, 1, 0, 16'hBEEF, 0, 0);
    check("beef_top", 32'(POP_output), 32'hBEEF);
    check("beef_depth", 32'(depth), 32'd2);
    step(0, 0, 0, 0, 1, 0);
    check("ret_top", 32'(POP_output), 32'h0011);
    step(0, 0, 0, 0, 1, 0);
    check("drained", 32'(stack_empty), 32'd1);

    for (int i = 0; i < 9; i++) step(1, 0, 16'h0100 + 16'(i), 0, 0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_top", 32'(POP_output), 32'h0108);
    step(0, 0, 0, 0, 1, 1);   // replace-less pop with clr: ovf cleared
    step(1, 0, 16'h0200, 0, 0, 0);
    step(1, 0, 16'h0300, 0, 1, 0); // replace at full, no overflow
    check("rep_full_ovf", 32'(overflow), 32'd0);
    step(1, 0, 16'h0400, 0, 0, 1); // overflow while clearing: stays set
    check("ovf_vs_clr", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);

    step(0, 0, 0, 0, 1, 0);
    check("unf_set", 32'(underflow), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    check("unf_clr", 32'(underflow), 32'd0);
    step(0, 0, 0, 0, 1, 1);
    check("unf_vs_clr", 32'(underflow), 32'd1);
    step(0, 1, 0, 16'h5555, 1, 1); // replace on empty: dropped, underflow
    check("rep_empty", 32'(depth), 32'd0);
    step(0, 0, 0, 0, 0, 1);

    step(0, 1, 0, 16'h1234, 0, 0);
    step(1, 0, 16'hFFFF, 0, 1, 0);
    check("wrap_top", 32'(POP_output), 32'h0000);
    check("wrap_depth", 32'(depth), 32'd1);
    step(1, 1, 16'h0020, 16'hAAAA, 0, 0);
    check("call_prio", 32'(POP_output), 32'h0021);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
           16'($urandom), 16'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));

    step(0, 0, 0, 0, 0, 1);
    while (mstk.size() > 5) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'hC000 + 16'(i), 0, 0);
    check("pre_rst_depth", 32'(depth), 32'(mstk.size()));
    #2 rst_n = 1'b0;
    #1;
    check("async_depth", 32'(depth), 32'd0);
    check("async_empty", 32'(stack_empty), 32'd1);
    check("async_top", 32'(POP_output), 32'h0);
    mstk.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_return_stack
